// File: rtl/sipo_frame_rx_pkg.sv
// rtl/sipo_frame_rx_pkg.sv - shared constants and sizing helpers for sipo_frame_rx.
// Optional feature macro: SIPO_FRAME_RX_PARITY_EN (adds a trailing even-parity bit per frame).
package sipo_frame_rx_pkg;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int clog2(input int n);
      int r;
      for (r = 0; (1 << r) < n; r++) begin
      end
      return r;
   endfunction

   // Bits per frame, including the parity bit when that feature is built in.
   function automatic int frame_len(input int width);
`ifdef SIPO_FRAME_RX_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/sipo_bit_cnt.sv
// rtl/sipo_bit_cnt.sv - modulo-LEN bit counter with enable, sync restart and terminal flag.
// Sync with enable counts the sampled bit as the first bit of a new frame.
module sipo_bit_cnt
   import sipo_frame_rx_pkg::*;
#(
   parameter int LEN = DEFAULT_WIDTH,
   parameter int CW  = clog2(LEN + 1)
) (
   input  logic          c,
   input  logic          rs,
   input  logic          en,
   input  logic          sy,
   output logic [CW-1:0] count,
   output logic          last
);

   assign last = (count == CW'(LEN - 1));

   always_ff @(posedge c or negedge rs) begin
      if (!rs) begin
         count <= '0;
      end else if (sy) begin
         count <= en ? CW'(1) : '0;
      end else if (en) begin
         count <= last ? '0 : count + CW'(1);
      end
   end

endmodule

// File: rtl/sipo_frame_rx.sv
// rtl/sipo_frame_rx.sv - MSB-first serial-to-parallel frame receiver with valid/ack and sticky overrun.
// Optional feature macro: SIPO_FRAME_RX_PARITY_EN (WIDTH data bits + even parity, perr output).
module sipo_frame_rx
   import sipo_frame_rx_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW    = clog2(WIDTH + 1)
) (
   input  logic             c,
   input  logic             rs,
   input  logic             d,
   input  logic             en,
   input  logic             sy,
   input  logic             ack,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             ovr,
`ifdef SIPO_FRAME_RX_PARITY_EN
   output logic             perr,
`endif
   output logic             busy
);

   localparam int FL  = frame_len(WIDTH);
   // The final bit of a frame is taken straight from d, so only FL-1 bits are stored.
   localparam int SRW = FL - 1;

   logic [CW-1:0]    count;
   logic             last;
   logic [SRW-1:0]   sr;
   logic [WIDTH-1:0] word;
   logic             fire;

   sipo_bit_cnt #(
      .LEN (FL),
      .CW  (CW)
   ) u_cnt (
      .c     (c),
      .rs    (rs),
      .en    (en),
      .sy    (sy),
      .count (count),
      .last  (last)
   );

`ifdef SIPO_FRAME_RX_PARITY_EN
   logic perr_next;
   assign word      = sr;
   assign perr_next = ^{sr, d};
`else
   assign word = {sr, d};
`endif

   assign fire = en & last & ~sy;
   assign busy = (count != '0);

   always_ff @(posedge c or negedge rs) begin
      if (!rs) begin
         sr    <= '0;
         dout  <= '0;
         valid <= 1'b0;
         ovr   <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
         perr  <= 1'b0;
`endif
      end else begin
         if (en) begin
            sr <= SRW'({sr, d});
         end
         if (fire) begin
            // An ack on the completion edge frees the slot for the new word.
            if (!valid || ack) begin
               dout  <= word;
               valid <= 1'b1;
`ifdef SIPO_FRAME_RX_PARITY_EN
               perr  <= perr_next;
`endif
            end else begin
               ovr <= 1'b1;
            end
         end else if (ack) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb/tb_sipo_frame_rx.sv - directed bench with a frame-level reference model for sipo_frame_rx.
// Optional feature macro: SIPO_FRAME_RX_PARITY_EN (bench then also drives parity bits and checks perr).
module tb_sipo_frame_rx;

   localparam int W = 8;
`ifdef SIPO_FRAME_RX_PARITY_EN
   localparam int FL = W + 1;
   localparam bit PAR = 1'b1;
`else
   localparam int FL = W;
   localparam bit PAR = 1'b0;
`endif

   logic         c = 1'b0;
   logic         rs;
   logic         d;
   logic         en;
   logic         sy;
   logic         ack;
   logic [W-1:0] dout;
   logic         valid;
   logic         ovr;
   logic         busy;
`ifdef SIPO_FRAME_RX_PARITY_EN
   logic         perr;
`endif

   int checks = 0;
   int errors = 0;

   sipo_frame_rx #(.WIDTH(W)) dut (
      .c     (c),
      .rs    (rs),
      .d     (d),
      .en    (en),
      .sy    (sy),
      .ack   (ack),
      .dout  (dout),
      .valid (valid),
      .ovr   (ovr),
`ifdef SIPO_FRAME_RX_PARITY_EN
      .perr  (perr),
`endif
      .busy  (busy)
   );

   always #5 c = ~c;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: tracks bits received in the current frame as a number.
   int          m_n     = 0;
   logic [63:0] m_acc   = '0;
   logic [63:0] m_dout  = '0;
   logic        m_valid = 1'b0;
   logic        m_ovr   = 1'b0;
   logic        m_perr  = 1'b0;

   always @(posedge c or negedge rs) begin
      bit done;
      if (!rs) begin
         m_n = 0; m_acc = '0; m_dout = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
      end else begin
         done = 0;
         if (sy) begin
            m_n   = en ? 1 : 0;
            m_acc = en ? 64'(d) : 64'd0;
         end else if (en) begin
            m_acc = m_acc * 2 + 64'(d);
            m_n   = m_n + 1;
            if (m_n == FL) done = 1;
         end
         if (done) begin
            if (!m_valid || ack) begin
               m_dout  = PAR ? (m_acc >> 1) : m_acc;
               m_valid = 1;
               m_perr  = ^m_acc;
            end else begin
               m_ovr = 1;
            end
            m_n = 0;
            m_acc = '0;
         end else if (ack) begin
            m_valid = 0;
         end
      end
   end

   always @(negedge c) begin
      chk("dout",  64'(dout),  m_dout);
      chk("valid", 64'(valid), 64'(m_valid));
      chk("ovr",   64'(ovr),   64'(m_ovr));
      chk("busy",  64'(busy),  64'(m_n != 0));
`ifdef SIPO_FRAME_RX_PARITY_EN
      chk("perr",  64'(perr),  64'(m_perr));
`endif
   end

   task automatic step(input logic dd, input logic ee, input logic ss, input logic aa);
      d = dd; en = ee; sy = ss; ack = aa;
      @(posedge c);
      @(negedge c);
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic p, input logic ack_last);
      for (int i = W - 1; i >= 0; i--)
         step(w[i], 1'b1, 1'b0, ack_last && (i == 0) && !PAR);
      if (PAR) step(p, 1'b1, 1'b0, ack_last);
   endtask

   initial begin
      logic [W-1:0] a5;
      rs = 1'b0; d = 1'b0; en = 1'b0; sy = 1'b0; ack = 1'b0;

      // Reset held while inputs toggle
      for (int i = 0; i < 4; i++) step(i[0], 1'b1, 1'b0, 1'b0);
      chk("rst_dout", 64'(dout), 64'h00);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_ovr", 64'(ovr), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rs = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_valid", 64'(valid), 64'd0);

      // Single word A5 with an en=0 gap mid-frame
      a5 = 8'hA5;
      for (int i = W - 1; i >= 0; i--) begin
         step(a5[i], 1'b1, 1'b0, 1'b0);
         if (i == 4) step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      if (PAR) step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("a5_dout", 64'(dout), 64'hA5);
      chk("a5_valid", 64'(valid), 64'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("a5_ack_valid", 64'(valid), 64'd0);
      chk("a5_ack_dout", 64'(dout), 64'hA5);

      // Ack on the completion edge
      send_word(8'h11, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b1);
      chk("ackc_dout", 64'(dout), 64'h22);
      chk("ackc_valid", 64'(valid), 64'd1);
      chk("ackc_ovr", 64'(ovr), 64'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Sync mid-frame
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("sync_busy", 64'(busy), 64'd1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (PAR) step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("sync_dout", 64'(dout), 64'h81);
      chk("sync_valid", 64'(valid), 64'd1);
      chk("sync_busy_done", 64'(busy), 64'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Sync on the last bit position suppresses completion
      for (int i = 0; i < FL - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("sypri_valid", 64'(valid), 64'd0);
      chk("sypri_busy", 64'(busy), 64'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("sypri_clr", 64'(busy), 64'd0);

      // Overrun
      send_word(8'h3C, 1'b0, 1'b0);
      send_word(8'hF0, 1'b0, 1'b0);
      chk("ovr_dout", 64'(dout), 64'h3C);
      chk("ovr_valid", 64'(valid), 64'd1);
      chk("ovr_flag", 64'(ovr), 64'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovr_ack_valid", 64'(valid), 64'd0);
      chk("ovr_sticky", 64'(ovr), 64'd1);

      // Async reset mid-frame
      for (int i = 0; i < 5; i++) step(i[0], 1'b1, 1'b0, 1'b0);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      #2 rs = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_ovr", 64'(ovr), 64'd0);
      #1 rs = 1'b1;
      send_word(8'h5A, 1'b1, 1'b0);
      chk("5a_dout", 64'(dout), 64'h5A);
      chk("5a_valid", 64'(valid), 64'd1);
`ifdef SIPO_FRAME_RX_PARITY_EN
      chk("5a_perr", 64'(perr), 64'd1);
`endif
      step(1'b0, 1'b0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Serial-in/parallel-out frame receiver.
- Sits directly downstream of the D flip-flop stage: its serial input d is driven by the flip-flop's q.
- Assembles WIDTH-bit words MSB-first and presents each completed word with a valid/acknowledge handshake.
- Flags overruns when the consumer is slow.

Parameters:
- WIDTH, 8, data bits per frame (legal 2..32).
- CW, $clog2(WIDTH+1), bit-counter width (derived; not overridden by users).

Ports:
- c  input  1  clock; all state updates on posedge c.
- rs  input  1  asynchronous active-low reset; rs=0 forces reset state immediately.
- d  input  1  serial data bit, normally the q of the preceding D flip-flop.
- en  input  1  shift enable; d is sampled only when en=1.
- sy  input  1  frame sync; restarts word assembly.
- ack  input  1  consumer acknowledge of current word.
- dout  output  WIDTH  last completed word.
- valid  output  1  dout holds an unacknowledged word.
- ovr  output  1  sticky overrun flag.
- busy  output  1  partial frame in progress (bit count != 0).

Behaviour:
- Reset (rs=0, asynchronous):
  - shift register=0, bit count=0, dout=0, valid=0, ovr=0, busy=0.
  - Reset mid-frame discards the partial word.
- Shift:
  - On posedge c with en=1: sr <= {sr[WIDTH-2:0], d}; count increments.
  - The first bit of a frame ends up in dout[WIDTH-1].
- Completion:
  - Completion occurs when en=1 and count==WIDTH-1.
  - That edge also clears count to 0.
  - The completed word {sr[WIDTH-2:0], d} loads into dout.
  - valid=1 from the following cycle; latency is 1 clock from the last bit's sampling edge to valid.
- Handshake:
  - valid stays high, and dout stays stable, until a posedge with ack=1 clears valid.
  - ack while valid=0 is ignored.
- Overrun (completion while valid=1 and ack=0):
  - The new word is dropped; dout keeps the old word.
  - ovr <= 1 and stays 1 until reset.
- Completion with ack=1 in the same cycle:
  - Accepted; dout takes the new word and valid stays 1.
  - No overrun.
- en=0: count, sr and dout hold; ack still works.
- Sync:
  - sy=1 at a posedge forces count to 0 and discards the partial word.
  - If en=1 in the same cycle, the sampled d becomes bit 1 of the new frame, so count=1 afterwards.
  - sy has priority over completion: with sy=1 at count==WIDTH-1, no word is emitted.
- busy: combinational (count != 0).
- No X propagation: all registers are reset.

Optional Feature:
- Macro SIPO_FRAME_RX_PARITY_EN.
- When defined:
  - A frame is WIDTH+1 bits: WIDTH data bits followed by one even-parity bit.
  - Completion occurs at the parity bit; the counter range becomes 0..WIDTH.
  - Extra output port perr (1 bit), reset 0. It updates with dout on each accepted word: 1 if XOR of data bits and parity bit is 1.
  - A dropped (overrun) word does not update perr.
- When undefined: no perr port; frame is WIDTH bits as above.

Decomposition:
- Package sipo_frame_rx_pkg holds:
  - default WIDTH constant
  - counter-width function (clog2)
  - frame-length constant: WIDTH, or WIDTH+1 under the macro
- One natural sub-module, sipo_bit_cnt: modulo-frame-length counter with en, sync clear and async active-low reset (c, rs).
- It outputs count and a terminal flag (last), consumed by the top for completion.

Test Plan:
- Reset: hold rs=0 while toggling d/en -> dout=8'h00, valid=0, ovr=0, busy=0. Release rs -> all unchanged until first en.
- Single word: en=1, feed 1,0,1,0,0,1,0,1 -> one cycle after the 8th edge, dout=8'hA5 and valid=1. Pulse ack -> valid=0, dout stays 8'hA5.
- Overrun: send 8'h3C, no ack, send 8'hF0 -> dout=8'h3C, valid=1, ovr=1. Pulse ack -> valid=0, ovr stays 1.
- Ack on completion edge: valid=1 with 8'h11, assert ack on the last-bit edge of 8'h22 -> dout=8'h22, valid=1, ovr=0.
- Sync mid-frame: 3 bits sent, then sy=1 with en=1, d=1, then 7 more bits 0,0,0,0,0,0,1 -> dout=8'h81. busy=1 during the frame, busy=0 after completion.
- Async reset mid-frame after 5 bits: rs=0 for a partial cycle -> busy=0 immediately. Then a full 8'h5A is received correctly. Under SIPO_FRAME_RX_PARITY_EN, 8'h5A with parity 1 -> perr=1.
